// File: rtl/servo_pwm_generator.sv
// Multi-channel servo PWM generator.
// Pulse widths are written through a valid/ready port into per-channel staging
// registers. They are committed to the active widths only at a frame boundary,
// so a pulse already in progress is never cut short or stretched. The frame
// position comes from an external free-running counter that wraps to zero once
// per frame.
//
// Write handshake: a write is accepted on any rising edge where WR_VALID and
// WR_READY are both high. WR_READY is low during reset and on the cycle where a
// frame boundary is detected. The writer must hold WR_CHANNEL and WR_WIDTH
// stable while WR_VALID is high and WR_READY is low.
module servo_pwm_generator #(
  parameter int CHANNELS            = 4,
  parameter int COUNTER_VALUE_WIDTH = 20,
  parameter int MIN_PULSE           = 50000,
  parameter int MAX_PULSE           = 100000,
  parameter int DEFAULT_PULSE       = 75000
) (
  input  logic                           PWM_CLOCK,
  input  logic                           PWM_RESET_N,
  input  logic [COUNTER_VALUE_WIDTH-1:0] COUNTER_VALUE,
  input  logic                           WR_VALID,
  input  logic [3:0]                     WR_CHANNEL,
  input  logic [COUNTER_VALUE_WIDTH-1:0] WR_WIDTH,
  output logic                           WR_READY,
  output logic                           WR_ERROR,
  output logic                           FRAME_STROBE,
  output logic [CHANNELS-1:0]            PWM_OUT
);

  localparam int W = COUNTER_VALUE_WIDTH;
  localparam logic [W-1:0] MIN_W     = W'(MIN_PULSE);
  localparam logic [W-1:0] MAX_W     = W'(MAX_PULSE);
  localparam logic [W-1:0] DEFAULT_W = W'(DEFAULT_PULSE);
  localparam logic [4:0]   CH_LIMIT  = 5'(CHANNELS);

  // WAIT_SYNC keeps the outputs quiet until the first frame boundary so the
  // first pulse is always a whole one; RUN is held until reset.
  typedef enum logic [0:0] {
    WAIT_SYNC = 1'b0,
    RUN       = 1'b1
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [W-1:0]         prev_count;
  logic                 ready_en;
  logic                 boundary;
  logic                 wr_ready;
  logic                 wr_accept;
  logic                 wr_ch_valid;
  logic [W-1:0]         wr_clamped;
  logic [W-1:0]         staging     [CHANNELS];
  logic [W-1:0]         active      [CHANNELS];
  logic [W-1:0]         active_next [CHANNELS];
  logic [CHANNELS-1:0]  pending;
  logic [CHANNELS-1:0]  pwm_next;

  // A boundary is the wrap to zero; a counter parked at zero does not retrigger.
  assign boundary    = (COUNTER_VALUE == '0) && (prev_count != '0);
  assign wr_ready    = ready_en && PWM_RESET_N && !boundary;
  assign wr_accept   = WR_VALID && wr_ready;
  assign wr_ch_valid = ({1'b0, WR_CHANNEL} < CH_LIMIT);
  assign WR_READY    = wr_ready;

  // Clamp the requested width into the servo's legal range.
  always_comb begin
    wr_clamped = WR_WIDTH;
    if (WR_WIDTH < MIN_W) begin
      wr_clamped = MIN_W;
    end else if (WR_WIDTH > MAX_W) begin
      wr_clamped = MAX_W;
    end
  end

  // Next-state logic: leave WAIT_SYNC on the first boundary, then stay in RUN.
  always_comb begin
    state_next = state;
    case (state)
      WAIT_SYNC: if (boundary) state_next = RUN;
      RUN:       state_next = RUN;
      default:   state_next = WAIT_SYNC;
    endcase
  end

  // Widths in force after this cycle's commit, and the PWM level they imply.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      active_next[i] = (boundary && pending[i]) ? staging[i] : active[i];
      pwm_next[i]    = (state_next == RUN) && (COUNTER_VALUE < active_next[i]);
    end
  end

  // State register, counter history, handshake enable and output pulses.
  always_ff @(posedge PWM_CLOCK) begin
    if (!PWM_RESET_N) begin
      state        <= WAIT_SYNC;
      prev_count   <= '0;
      ready_en     <= 1'b0;
      WR_ERROR     <= 1'b0;
      FRAME_STROBE <= 1'b0;
      PWM_OUT      <= '0;
    end else begin
      state        <= state_next;
      prev_count   <= COUNTER_VALUE;
      ready_en     <= 1'b1;
      WR_ERROR     <= wr_accept && !wr_ch_valid;
      FRAME_STROBE <= boundary;
      PWM_OUT      <= pwm_next;
    end
  end

  // Per-channel staging/active/pending; writes and commits never coincide
  // because the port is not ready on a boundary cycle.
  always_ff @(posedge PWM_CLOCK) begin
    if (!PWM_RESET_N) begin
      pending <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        staging[i] <= DEFAULT_W;
        active[i]  <= DEFAULT_W;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        active[i] <= active_next[i];
        if (wr_accept && wr_ch_valid && (WR_CHANNEL == 4'(i))) begin
          staging[i] <= wr_clamped;
          pending[i] <= 1'b1;
        end else if (boundary) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_generator.sv
// Bench for servo_pwm_generator: a free-running 0..199 frame counter drives
// the block; measured high time per channel per frame is compared against the
// widths expected for that frame.
module tb_servo_pwm_generator;

  localparam int CH    = 4;
  localparam int W     = 8;
  localparam int MINP  = 10;
  localparam int MAXP  = 40;
  localparam int DEFP  = 25;
  localparam int FRAME = 200;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  counter_value;
  logic          wr_valid;
  logic [3:0]    wr_channel;
  logic [W-1:0]  wr_width;
  logic          wr_ready;
  logic          wr_error;
  logic          frame_strobe;
  logic [CH-1:0] pwm_out;

  servo_pwm_generator #(
    .CHANNELS            (CH),
    .COUNTER_VALUE_WIDTH (W),
    .MIN_PULSE           (MINP),
    .MAX_PULSE           (MAXP),
    .DEFAULT_PULSE       (DEFP)
  ) dut (
    .PWM_CLOCK     (clk),
    .PWM_RESET_N   (rst_n),
    .COUNTER_VALUE (counter_value),
    .WR_VALID      (wr_valid),
    .WR_CHANNEL    (wr_channel),
    .WR_WIDTH      (wr_width),
    .WR_READY      (wr_ready),
    .WR_ERROR      (wr_error),
    .FRAME_STROBE  (frame_strobe),
    .PWM_OUT       (pwm_out)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard state
  int total = 0;
  int bad   = 0;
  logic [CH*W-1:0] exp_q[$];

  int            cnt;
  logic [W-1:0]  model_prev;
  logic          rst_prev_edge;
  logic [W-1:0]  exp_w [CH];
  logic [W-1:0]  stg   [CH];
  logic [CH-1:0] pend;
  logic          last_rst_low;
  logic          last_bnd;
  logic          last_err_exp;
  logic          skip_obs;
  int            hi_cnt [CH];
  int            strobe_cnt;
  int            pre_hi;
  logic          window_open;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] clamp(input logic [W-1:0] x);
    if (x < W'(MINP)) return W'(MINP);
    if (x > W'(MAXP)) return W'(MAXP);
    return x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      exp_w[i] = W'(DEFP);
      stg[i]   = W'(DEFP);
    end
    pend       = '0;
    model_prev = '0;
  endtask

  // Inspect outputs produced by the edge that just passed.
  task automatic observe();
    logic [CH*W-1:0] e;
    if (skip_obs) begin
      skip_obs = 1'b0;
      return;
    end
    if (last_rst_low) begin
      check_eq("rst_pwm", 32'(pwm_out), 0);
      check_eq("rst_strobe", 32'(frame_strobe), 0);
      check_eq("rst_err", 32'(wr_error), 0);
      for (int i = 0; i < CH; i++) hi_cnt[i] = 0;
      strobe_cnt  = 0;
      pre_hi      = 0;
      window_open = 1'b0;
      exp_q.delete();
      return;
    end
    if (last_bnd) begin
      if (window_open) begin
        check_eq("exp_q_nonempty", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          for (int i = 0; i < CH; i++)
            check_eq($sformatf("width_ch%0d", i), 32'(hi_cnt[i]), 32'(e[i*W +: W]));
          check_eq("strobe_per_frame", 32'(strobe_cnt), 1);
        end
      end else begin
        check_eq("sync_low", 32'(pre_hi), 0);
      end
      for (int i = 0; i < CH; i++) hi_cnt[i] = 0;
      strobe_cnt  = 0;
      window_open = 1'b1;
    end
    check_eq("wr_error", 32'(wr_error), 32'(last_err_exp));
    for (int i = 0; i < CH; i++) begin
      if (pwm_out[i]) begin
        if (window_open) hi_cnt[i]++;
        else pre_hi++;
      end
    end
    if (frame_strobe) begin
      if (window_open) strobe_cnt++;
      else pre_hi++;
    end
  endtask

  // Driver: one clock of stimulus, with the expected-result model stepped alongside.
  task automatic step(input logic v, input logic [3:0] ch, input logic [W-1:0] w,
                      input logic rv, output logic rdy);
    logic bnd;
    logic ready_exp;
    logic acc;
    @(negedge clk);
    observe();
    rst_n         = rv;
    counter_value = W'(cnt);
    wr_valid      = v;
    wr_channel    = ch;
    wr_width      = w;
    #1;
    bnd       = (W'(cnt) == '0) && (model_prev != '0);
    ready_exp = rv && rst_prev_edge && !bnd;
    check_eq("wr_ready", 32'(wr_ready), 32'(ready_exp));
    rdy          = wr_ready;
    acc          = v && ready_exp;
    last_rst_low = !rv;
    last_bnd     = 1'b0;
    last_err_exp = 1'b0;
    if (!rv) begin
      model_reset();
    end else begin
      if (bnd) begin
        for (int i = 0; i < CH; i++) begin
          if (pend[i]) begin
            exp_w[i] = stg[i];
            pend[i]  = 1'b0;
          end
        end
        last_bnd = 1'b1;
        exp_q.push_back({exp_w[3], exp_w[2], exp_w[1], exp_w[0]});
      end
      if (acc && (ch < 4'(CH))) begin
        stg[ch[1:0]]  = clamp(w);
        pend[ch[1:0]] = 1'b1;
      end
      last_err_exp = acc && (ch >= 4'(CH));
      model_prev   = W'(cnt);
    end
    rst_prev_edge = rv;
    cnt = (cnt == FRAME - 1) ? 0 : cnt + 1;
  endtask

  task automatic idle_to(input int target);
    logic r;
    for (int k = 0; k < FRAME + 1; k++) begin
      if (cnt == target) break;
      step(1'b0, 4'd0, '0, 1'b1, r);
    end
  endtask

  task automatic write_hs(input logic [3:0] ch, input logic [W-1:0] w, output int tries);
    logic r;
    r     = 1'b0;
    tries = 0;
    while (!r && tries < 4) begin
      step(1'b1, ch, w, 1'b1, r);
      tries++;
    end
    check_eq("hs_accept", 32'(r), 1);
  endtask

  // Test sequence
  initial begin
    logic r;
    int   tries;
    rst_n         = 1'b0;
    counter_value = '0;
    wr_valid      = 1'b0;
    wr_channel    = '0;
    wr_width      = '0;
    cnt           = 0;
    skip_obs      = 1'b1;
    rst_prev_edge = 1'b0;
    last_rst_low  = 1'b0;
    last_bnd      = 1'b0;
    last_err_exp  = 1'b0;
    window_open   = 1'b0;
    strobe_cnt    = 0;
    pre_hi        = 0;
    for (int i = 0; i < CH; i++) hi_cnt[i] = 0;
    model_reset();

    repeat (3) step(1'b0, 4'd0, '0, 1'b0, r);

    // Frame 0: waiting for sync, outputs must stay low.
    idle_to(0);
    // Frame 1: defaults; ch1=30 written mid-frame.
    idle_to(100);
    write_hs(4'd1, 8'd30, tries);
    idle_to(0);
    // Frame 2: ch1 at 30; out-of-range widths for ch2/ch3.
    idle_to(50);
    write_hs(4'd2, 8'd5, tries);
    write_hs(4'd3, 8'd60, tries);
    idle_to(0);
    // Frame 3: clamped widths; write held across the wrap.
    idle_to(199);
    idle_to(0);
    write_hs(4'd0, 8'd12, tries);
    check_eq("hs_wrap_tries", 32'(tries), 2);
    // Frame 4: ch0 still old width; invalid channel write.
    idle_to(30);
    write_hs(4'd7, 8'd20, tries);
    check_eq("err_tries", 32'(tries), 1);
    idle_to(0);
    // Frame 5: ch0=12 takes effect; random writes.
    for (int k = 0; k < 3; k++) begin
      idle_to(40 + k * 50 + int'($urandom_range(0, 30)));
      write_hs(4'($urandom_range(1, 3)), 8'($urandom_range(0, 80)), tries);
    end
    idle_to(0);
    // Frame 6: random widths in force.
    idle_to(199);
    idle_to(0);
    // Frame 7: pending ch0=35, then reset at count 5.
    idle_to(2);
    write_hs(4'd0, 8'd35, tries);
    idle_to(5);
    step(1'b0, 4'd0, '0, 1'b0, r);
    idle_to(0);
    // Frame 8: resynchronised, defaults everywhere.
    idle_to(199);
    idle_to(0);
    step(1'b0, 4'd0, '0, 1'b1, r);
    step(1'b0, 4'd0, '0, 1'b1, r);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
